// File: rtl/downsample_scaler.sv
// Camera RGB stream decimator: pick or horizontal box-average by 2^FACTOR_LOG2 per axis,
// producing gray plus truncated RGB, a linear frame-buffer address and a frame-done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | reset state, source not yet enabled
// WAIT_SOF | source enabled, pixels discarded until a valid SOF pixel
// RUN      | frame in progress, counters free-run across frame ends
module downsample_scaler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int FACTOR_LOG2 = 1,
    parameter int IN_W        = 10,
    parameter int OUT_W       = 8,
    parameter int ADDR_W      = 17
) (
    input  logic              iCLK,
    input  logic              iRESET_N,
    input  logic              iVALID,
    input  logic              iSOF,
    input  logic [IN_W-1:0]   iRED,
    input  logic [IN_W-1:0]   iGREEN,
    input  logic [IN_W-1:0]   iBLUE,
    input  logic [1:0]        iMODE,
    input  logic              iAVG,
    output logic              oREAD,
    output logic              oWREN,
    output logic [ADDR_W-1:0] oADDR,
    output logic [OUT_W-1:0]  oDATA,
    output logic [OUT_W-1:0]  oDATA_R,
    output logic [OUT_W-1:0]  oDATA_G,
    output logic [OUT_W-1:0]  oDATA_B,
    output logic              oFRAME_DONE
);

    localparam int F        = 1 << FACTOR_LOG2;
    localparam int MAX_ADDR = (WIDTH / F) * (HEIGHT / F);
    localparam int XW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW       = IN_W + FACTOR_LOG2;
    localparam int SHIFT    = IN_W - OUT_W;

    localparam logic [XW-1:0]     X_MASK    = XW'(F - 1);
    localparam logic [YW-1:0]     Y_MASK    = YW'(F - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_ADDR - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN} state_t;

    state_t state, state_next;

    logic [XW-1:0]     xcnt, x_cur;
    logic [YW-1:0]     ycnt, y_cur;
    logic [ADDR_W-1:0] addr_q, addr_cur;
    logic [AW-1:0]     acc_r, acc_g, acc_b;
    logic [AW-1:0]     acc_r_next, acc_g_next, acc_b_next;
    logic [1:0]        mode_q, mode_cur;
    logic              avg_q, avg_cur;
    logic              sof_acc, pix_acc, grp_first, grp_last, row_keep, write, addr_last;
    logic [IN_W-1:0]   sel_r, sel_g, sel_b, gray_full;

    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = WAIT_SOF;
            WAIT_SOF: if (iVALID && iSOF) state_next = RUN;
            RUN:      state_next = RUN;
            default:  state_next = IDLE;
        endcase
    end

    // An accepted SOF pixel is treated as (0,0) with freshly latched modes.
    always_comb begin
        sof_acc    = iVALID && iSOF && (state != IDLE);
        pix_acc    = sof_acc || (iVALID && (state == RUN));
        x_cur      = sof_acc ? '0 : xcnt;
        y_cur      = sof_acc ? '0 : ycnt;
        addr_cur   = sof_acc ? '0 : addr_q;
        mode_cur   = sof_acc ? iMODE : mode_q;
        avg_cur    = sof_acc ? iAVG : avg_q;
        grp_first  = (x_cur & X_MASK) == '0;
        grp_last   = (x_cur & X_MASK) == X_MASK;
        row_keep   = (y_cur & Y_MASK) == '0;
        acc_r_next = (grp_first ? '0 : acc_r) + AW'(iRED);
        acc_g_next = (grp_first ? '0 : acc_g) + AW'(iGREEN);
        acc_b_next = (grp_first ? '0 : acc_b) + AW'(iBLUE);
        write      = pix_acc && row_keep && (avg_cur ? grp_last : grp_first);
        addr_last  = addr_cur == ADDR_LAST;
        sel_r      = avg_cur ? IN_W'(acc_r_next >> FACTOR_LOG2) : iRED;
        sel_g      = avg_cur ? IN_W'(acc_g_next >> FACTOR_LOG2) : iGREEN;
        sel_b      = avg_cur ? IN_W'(acc_b_next >> FACTOR_LOG2) : iBLUE;
        case (mode_cur)
            2'd0:    gray_full = IN_W'(({2'b00, sel_r} + {2'b00, sel_b}) >> 1);
            2'd1:    gray_full = IN_W'(({2'b00, sel_r} + {1'b0, sel_g, 1'b0} + {2'b00, sel_b}) >> 2);
            2'd2:    gray_full = sel_r;
            default: gray_full = sel_b;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            xcnt        <= '0;
            ycnt        <= '0;
            addr_q      <= '0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            mode_q      <= '0;
            avg_q       <= 1'b0;
            oREAD       <= 1'b0;
            oWREN       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oADDR       <= '0;
            oDATA       <= '0;
            oDATA_R     <= '0;
            oDATA_G     <= '0;
            oDATA_B     <= '0;
        end else begin
            oREAD       <= (state_next != IDLE);
            oWREN       <= write;
            oFRAME_DONE <= write && addr_last;
            if (sof_acc) begin
                mode_q <= iMODE;
                avg_q  <= iAVG;
            end
            if (pix_acc) begin
                if (x_cur == X_LAST) begin
                    xcnt <= '0;
                    ycnt <= (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
                end else begin
                    xcnt <= x_cur + 1'b1;
                    ycnt <= y_cur;
                end
                if (row_keep) begin
                    acc_r <= acc_r_next;
                    acc_g <= acc_g_next;
                    acc_b <= acc_b_next;
                end
            end
            if (write) begin
                oADDR   <= addr_cur;
                oDATA   <= OUT_W'(gray_full >> SHIFT);
                oDATA_R <= OUT_W'(sel_r >> SHIFT);
                oDATA_G <= OUT_W'(sel_g >> SHIFT);
                oDATA_B <= OUT_W'(sel_b >> SHIFT);
                addr_q  <= addr_last ? '0 : addr_cur + 1'b1;
            end else if (sof_acc) begin
                addr_q  <= '0;
            end
        end
    end

endmodule
